// File: rtl/cache_ctrl.sv
// Direct-mapped, one-word-line, write-back / write-allocate cache controller.
// Optional hit/miss statistics are built only when CACHE_STATS_EN is defined.
module cache_ctrl #(
    parameter int INDEX_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [23:0]           addr,
    input  logic                  mode,
    input  logic [31:0]           inData,
    output logic [31:0]           outData,
    output logic                  resp_valid,
    output logic                  hit,
    output logic [INDEX_BITS-1:0] cache_index,
    output logic                  cache_we,
    output logic [31:0]           cache_wdata,
    input  logic [31:0]           cache_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [23:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 24 - INDEX_BITS;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND} state_t;

    state_t            state_q, state_d;
    logic [23:0]       addr_q, addr_d;
    logic              mode_q, mode_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic [31:0]       out_q, out_d;
    logic              hit_q, hit_d;
    logic [LINES-1:0]  valid_q, dirty_q;
    logic [TAG_W-1:0]  tag_q [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic                  line_hit;
    logic                  fill_line, fill_dirty, set_dirty;

    assign idx      = addr_q[INDEX_BITS-1:0];
    assign tag      = addr_q[23:INDEX_BITS];
    assign line_hit = valid_q[idx] && (tag_q[idx] == tag);

    assign outData = out_q;
    assign hit     = hit_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mode_d      = mode_q;
        wdata_d     = wdata_q;
        wb_data_d   = wb_data_q;
        out_d       = out_q;
        hit_d       = hit_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        cache_index = idx;
        cache_we    = 1'b0;
        cache_wdata = wdata_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = addr_q;
        mem_wdata   = wb_data_q;
        fill_line   = 1'b0;
        fill_dirty  = 1'b0;
        set_dirty   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready   = 1'b1;
                // Present the incoming index so array data is ready in LOOKUP.
                cache_index = addr[INDEX_BITS-1:0];
                if (req_valid) begin
                    addr_d  = addr;
                    mode_d  = mode;
                    wdata_d = inData;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (line_hit) begin
                    hit_d   = 1'b1;
                    state_d = RESPOND;
                    if (mode_q) begin
                        cache_we  = 1'b1;
                        set_dirty = 1'b1;
                    end else begin
                        out_d = cache_rdata;
                    end
                end else begin
                    hit_d     = 1'b0;
                    wb_data_d = cache_rdata;
                    state_d   = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {tag_q[idx], idx};
                if (mem_ack) state_d = FILL;
            end
            FILL: begin
                if (mode_q) begin
                    // Write-allocate: the whole line is overwritten, no RAM read.
                    cache_we   = 1'b1;
                    fill_line  = 1'b1;
                    fill_dirty = 1'b1;
                    state_d    = RESPOND;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        cache_we    = 1'b1;
                        cache_wdata = mem_rdata;
                        fill_line   = 1'b1;
                        out_d       = mem_rdata;
                        state_d     = RESPOND;
                    end
                end
            end
            RESPOND: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            mode_q    <= 1'b0;
            wdata_q   <= '0;
            wb_data_q <= '0;
            out_q     <= '0;
            hit_q     <= 1'b0;
            valid_q   <= '0;
            dirty_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            mode_q    <= mode_d;
            wdata_q   <= wdata_d;
            wb_data_q <= wb_data_d;
            out_q     <= out_d;
            hit_q     <= hit_d;
            if (fill_line) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= fill_dirty;
            end
            if (set_dirty) dirty_q[idx] <= 1'b1;
        end
    end

    // Tags need no reset: a line is only trusted through its valid bit.
    always_ff @(posedge clk) begin
        if (fill_line) tag_q[idx] <= tag;
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (resp_valid) begin
            if (hit_q) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized bench for cache_ctrl with a line-level cache model, a RAM
// responder with programmable ack delay, and a one-cycle-latency data array.
module tb_cache_ctrl;
    localparam int IB = 8;
    localparam int NL = 1 << IB;

    logic          clk, rst;
    logic          req_valid, req_ready, mode;
    logic [23:0]   addr;
    logic [31:0]   inData, outData;
    logic          resp_valid, hit;
    logic [IB-1:0] cache_index;
    logic          cache_we;
    logic [31:0]   cache_wdata, cache_rdata;
    logic          mem_req, mem_we, mem_ack;
    logic [23:0]   mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [15:0]   hit_count, miss_count;

    cache_ctrl #(.INDEX_BITS(IB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .addr(addr), .mode(mode), .inData(inData), .outData(outData),
        .resp_valid(resp_valid), .hit(hit), .cache_index(cache_index),
        .cache_we(cache_we), .cache_wdata(cache_wdata), .cache_rdata(cache_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // External data array: synchronous write, registered read.
    logic [31:0] arr [NL];
    logic [31:0] arr_rd;
    initial for (int i = 0; i < NL; i++) arr[i] = 32'h0;
    always @(posedge clk) begin
        if (cache_we) arr[cache_index] <= cache_wdata;
        arr_rd <= arr[cache_index];
    end
    assign cache_rdata = arr_rd;

    // Backing RAM: unwritten words read as a hash of the address (0 at 0).
    logic [31:0] ram [int];
    function automatic logic [31:0] ram_rd(input logic [23:0] a);
        if (ram.exists(int'({8'h0, a}))) return ram[int'({8'h0, a})];
        return {8'h0, a} * 32'h9E3779B1;
    endfunction

    typedef struct {
        logic        we;
        logic [23:0] a;
        logic [31:0] d;
    } mtx_t;
    mtx_t mlog[$];
    mtx_t elog[$];
    int   ack_delay = 0;

    // RAM responder: acks after ack_delay waiting cycles, checks request stability,
    // and throws spurious acks while no request is pending.
    initial begin
        int   cnt;
        mtx_t cur;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (rst || !mem_req) begin
                cnt = 0;
                mem_ack = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end else begin
                if (cnt == 0) begin
                    cur.we = mem_we; cur.a = mem_addr; cur.d = mem_wdata;
                    mlog.push_back(cur);
                end else begin
                    check("mem_we_stable", {31'h0, mem_we}, {31'h0, cur.we});
                    check("mem_addr_stable", {8'h0, mem_addr}, {8'h0, cur.a});
                    if (cur.we) check("mem_wdata_stable", mem_wdata, cur.d);
                end
                if (cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = cur.we ? $urandom : ram_rd(cur.a);
                    if (cur.we) ram[int'({8'h0, cur.a})] = cur.d;
                    cnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    cnt++;
                end
            end
        end
    end

    // Cache model, indexed by line.
    logic        mv [NL];
    logic        md [NL];
    logic [15:0] mt [NL];
    logic [31:0] mdat [NL];

    logic        pend_hit = 1'b0, pend_read = 1'b0;
    logic [31:0] pend_out = 32'h0;
    logic [31:0] exp_out = 32'h0;
    int          ehc = 0, emc = 0;

    // Per-cycle output compare against the model.
    initial begin
        logic prev_rv;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_out = 32'h0; ehc = 0; emc = 0; prev_rv = 1'b0;
            end else begin
`ifdef CACHE_STATS_EN
                check("hit_count", {16'h0, hit_count}, ehc);
                check("miss_count", {16'h0, miss_count}, emc);
`else
                check("hit_count", {16'h0, hit_count}, 32'h0);
                check("miss_count", {16'h0, miss_count}, 32'h0);
`endif
                if (resp_valid) begin
                    check("resp_single_cycle", {31'h0, prev_rv}, 32'h0);
                    check("hit", {31'h0, hit}, {31'h0, pend_hit});
                    if (pend_read) exp_out = pend_out;
                    check("outData_resp", outData, exp_out);
                    if (pend_hit) begin if (ehc < 65535) ehc++; end
                    else begin if (emc < 65535) emc++; end
                end else begin
                    check("outData_hold", outData, exp_out);
                end
                prev_rv = resp_valid;
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
    endtask

    // One request: predict, drive, wait for the response, compare latency and RAM traffic.
    task automatic do_req(input logic [23:0] a, input logic m, input logic [31:0] wd,
                          input int d, output int lat, output logic got_hit);
        logic [IB-1:0] ix;
        logic [15:0]   tg;
        logic          h, wb;
        int            elat;
        mtx_t          t;
        ix = a[IB-1:0];
        tg = a[23:IB];
        h  = mv[ix] && (mt[ix] == tg);
        wb = !h && mv[ix] && md[ix];
        @(negedge clk);
        elog.delete();
        mlog.delete();
        if (wb) begin t.we = 1'b1; t.a = {mt[ix], ix}; t.d = mdat[ix]; elog.push_back(t); end
        if (!h && !m) begin t.we = 1'b0; t.a = a; t.d = 32'h0; elog.push_back(t); end
        elat = 2 + (wb ? d + 1 : 0) + (h ? 0 : (m ? 1 : d + 1));
        pend_hit  = h;
        pend_read = !m;
        pend_out  = h ? mdat[ix] : ram_rd(a);
        ack_delay = d;
        req_valid = 1'b1; addr = a; mode = m; inData = wd;
        check("req_ready_idle", {31'h0, req_ready}, 32'h1);
        lat = 0;
        got_hit = 1'b0;
        forever begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                req_valid = 1'b0; addr = $urandom; mode = $urandom; inData = $urandom;
            end
            if (resp_valid) begin got_hit = hit; break; end
            check("req_ready_busy", {31'h0, req_ready}, 32'h0);
            if (lat > 400) begin
                check("resp_timeout", 32'h0, 32'h1);
                break;
            end
        end
        check("latency", lat, elat);
        check("mem_txn_count", mlog.size(), elog.size());
        for (int i = 0; i < elog.size() && i < mlog.size(); i++) begin
            check("mem_txn_we", {31'h0, mlog[i].we}, {31'h0, elog[i].we});
            check("mem_txn_addr", {8'h0, mlog[i].a}, {8'h0, elog[i].a});
            if (elog[i].we) check("mem_txn_wdata", mlog[i].d, elog[i].d);
        end
        if (m) begin
            mv[ix] = 1'b1; md[ix] = 1'b1; mt[ix] = tg; mdat[ix] = wd;
        end else if (!h) begin
            mv[ix] = 1'b1; md[ix] = 1'b0; mt[ix] = tg; mdat[ix] = pend_out;
        end
    endtask

    initial begin
        int          lat;
        logic        gh;
        logic [23:0] a;
        logic [15:0] tags [4];
        logic [7:0]  idxs [4];
        int          waited;
        tags[0] = 16'h0000; tags[1] = 16'hA7E5; tags[2] = 16'h0015; tags[3] = 16'h3C3C;
        idxs[0] = 8'h00;    idxs[1] = 8'h01;    idxs[2] = 8'hFB;    idxs[3] = 8'h7E;
        req_valid = 1'b0; addr = 24'h0; mode = 1'b0; inData = 32'h0;
        model_reset();
        rst = 1'b1;
        #1;
        check("rst_outData", outData, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_hit", {31'h0, hit}, 32'h0);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_cache_we", {31'h0, cache_we}, 32'h0);
        check("rst_hit_count", {16'h0, hit_count}, 32'h0);
        check("rst_miss_count", {16'h0, miss_count}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Cold read of address 0.
        do_req(24'h000000, 1'b0, 32'h0, 2, lat, gh);
        check("r0_lat_lit", lat, 5);
        check("r0_hit_lit", {31'h0, gh}, 32'h0);
        check("r0_out_lit", outData, 32'h0);

        // Write-allocate miss then read hit.
        do_req(24'hA7E5FB, 1'b1, 32'd46426, 3, lat, gh);
        check("w_lat_lit", lat, 3);
        check("w_no_ram_lit", mlog.size(), 0);
        do_req(24'hA7E5FB, 1'b0, 32'h0, 3, lat, gh);
        check("rh_lat_lit", lat, 2);
        check("rh_hit_lit", {31'h0, gh}, 32'h1);
        check("rh_out_lit", outData, 32'd46426);

        // Conflict read forces writeback of the dirty line, 10-cycle ack waits.
        do_req(24'h0015FB, 1'b0, 32'h0, 10, lat, gh);
        check("wb_lat_lit", lat, 24);
        check("wb_n_lit", mlog.size(), 2);
        if (mlog.size() == 2) begin
            check("wb_addr_lit", {8'h0, mlog[0].a}, 32'h00A7E5FB);
            check("wb_data_lit", mlog[0].d, 32'd46426);
            check("fill_addr_lit", {8'h0, mlog[1].a}, 32'h000015FB);
        end
        check("wb_out_lit", outData, ram_rd(24'h0015FB));

        // Reset in the middle of FILL.
        @(negedge clk);
        ack_delay = 50;
        req_valid = 1'b1; addr = 24'h123456; mode = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        waited = 0;
        while (!mem_req && waited < 20) begin @(negedge clk); waited++; end
        check("fill_started", {31'h0, mem_req}, 32'h1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_fill_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_fill_resp", {31'h0, resp_valid}, 32'h0);
        check("rst_fill_ready", {31'h0, req_ready}, 32'h1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_no_resp", {31'h0, resp_valid}, 32'h0);
        end
        do_req(24'h123456, 1'b0, 32'h0, 1, lat, gh);
        check("post_rst_miss_lit", {31'h0, gh}, 32'h0);

        // Statistics: this read was the first miss; add 3 hits and 1 more miss.
        do_req(24'h123456, 1'b0, 32'h0, 0, lat, gh);
        do_req(24'h123456, 1'b1, 32'h55AA, 0, lat, gh);
        do_req(24'h777701, 1'b1, 32'h1234, 0, lat, gh);
        do_req(24'h777701, 1'b0, 32'h0, 0, lat, gh);
        @(negedge clk);
`ifdef CACHE_STATS_EN
        check("stats_hits_lit", {16'h0, hit_count}, 32'd3);
        check("stats_miss_lit", {16'h0, miss_count}, 32'd2);
`else
        check("stats_hits_lit", {16'h0, hit_count}, 32'd0);
        check("stats_miss_lit", {16'h0, miss_count}, 32'd0);
`endif

        // Random traffic over a small set of tags/indices to provoke conflicts.
        for (int n = 0; n < 300; n++) begin
            a = {tags[$urandom_range(0, 3)],
                 ($urandom_range(0, 4) == 0) ? 8'($urandom) : idxs[$urandom_range(0, 3)]};
            do_req(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3), lat, gh);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 The block SHALL have parameter INDEX_BITS, default 8, meaning number of index bits (2^INDEX_BITS one-word direct-mapped lines).
REQ-002 The block SHALL have clk  input  1  system clock; all state updates on the rising edge.
REQ-003 The block SHALL have rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have the CPU-side ports:
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when high.
- addr  input  24  word address.
- mode  input  1  0 = read, 1 = write.
- inData  input  32  write data.
REQ-005 The block SHALL have the response ports:
- outData  output  32  read data.
- resp_valid  output  1  one-cycle completion pulse.
- hit  output  1  hit flag, qualified by resp_valid.
REQ-006 The block SHALL have the cache data-array ports:
- cache_index  output  INDEX_BITS  line index.
- cache_we  output  1  array write enable.
- cache_wdata  output  32  array write data.
- cache_rdata  input  32  array read data, valid one cycle after cache_index.
REQ-007 The block SHALL have the RAM ports:
- mem_req  output  1  RAM request.
- mem_we  output  1  RAM write.
- mem_addr  output  24  RAM address.
- mem_wdata  output  32  RAM write data.
- mem_rdata  input  32  RAM read data.
- mem_ack  input  1  one-cycle completion from RAM.
REQ-008 The block SHALL have hit_count  output  16  and miss_count  output  16  statistics counters (see Configuration).

Function
REQ-009 The block SHALL split addr as tag = addr[23:INDEX_BITS] and index = addr[INDEX_BITS-1:0], and SHALL hold per-line valid, dirty and tag registers internally.
REQ-010 The state machine SHALL have the states IDLE, LOOKUP, WRITEBACK, FILL and RESPOND.
REQ-011 In IDLE, req_ready SHALL be 1, and cache_index SHALL equal addr[INDEX_BITS-1:0]; req_ready SHALL be 0 in every other state.
REQ-012 A request SHALL be accepted when req_valid and req_ready are both 1: addr, mode and inData are latched and the next state is LOOKUP.
REQ-013 LOOKUP read hit (valid and tag match): outData <= cache_rdata, hit <= 1, next state RESPOND.
REQ-014 LOOKUP write hit: cache_we = 1 for one cycle with cache_wdata = latched inData, dirty <= 1, hit <= 1, next state RESPOND.
REQ-015 LOOKUP miss with the victim line valid and dirty: next state WRITEBACK, with hit <= 0.
REQ-016 LOOKUP miss with the victim line clean or invalid: next state FILL, with hit <= 0.
REQ-017 WRITEBACK SHALL hold mem_req = 1, mem_we = 1, mem_addr = {stored tag, index} and mem_wdata = victim data captured in LOOKUP, until mem_ack; on mem_ack the next state is FILL.
REQ-018 FILL for a read SHALL hold mem_req = 1, mem_we = 0, mem_addr = latched addr, until mem_ack. On mem_ack it SHALL:
- write mem_rdata to the cache line;
- set tag, valid = 1, dirty = 0;
- set outData = mem_rdata;
- go to RESPOND.
REQ-019 FILL for a write (write-allocate, no RAM read) SHALL, in one cycle:
- write inData to the line;
- set tag, valid = 1, dirty = 1;
- go to RESPOND.
REQ-020 RESPOND SHALL assert resp_valid for exactly one cycle and then return to IDLE.
REQ-021 Read-hit latency SHALL be 2 cycles from acceptance to resp_valid; miss latency is the hit latency plus the RAM ack waits.
REQ-022 mem_ack arriving while mem_req = 0 SHALL be ignored.
REQ-023 mem_req, mem_we, mem_addr and mem_wdata SHALL remain stable from assertion until mem_ack.
REQ-024 outData SHALL hold its last value until the next read completes; a write response SHALL NOT change outData.

Reset
REQ-025 rst SHALL immediately force the state to IDLE and clear every valid and dirty bit.
REQ-026 rst SHALL force the following outputs to 0: outData, resp_valid, hit, mem_req, mem_we, cache_we, hit_count and miss_count.
REQ-027 rst during WRITEBACK or FILL SHALL drop mem_req at once, produce no response, and leave no line marked valid.

Configuration
REQ-028 With CACHE_STATS_EN defined, each response SHALL increment hit_count (hit) or miss_count (miss), and both counters SHALL saturate at 16'hFFFF.
REQ-029 Without CACHE_STATS_EN, hit_count and miss_count SHALL be constant 0, and the counter logic SHALL be absent.

Verification
REQ-030 Reset, then read addr 0 -> miss, no writeback, FILL; mem_ack with mem_rdata = 0 -> outData = 0, hit = 0.
REQ-031 Write addr 24'hA7E5FB with data 46426 (miss, clean) -> no RAM access, resp_valid 2 cycles after acceptance plus the FILL cycle, line dirty; read the same address -> hit = 1, outData = 46426, resp_valid 2 cycles after acceptance.
REQ-032 Write addr 24'hA7E5FB with data 46426, then read 24'h0015FB (same index, different tag) -> WRITEBACK with mem_addr = 24'hA7E5FB and mem_wdata = 46426, then FILL with mem_addr = 24'h0015FB.
REQ-033 Hold mem_ack low for 10 cycles in FILL -> mem_req and mem_addr are stable throughout, req_ready = 0, and resp_valid follows the ack by 1 cycle.
REQ-034 Assert rst in the middle of FILL -> mem_req = 0 in the same cycle; a subsequent read of the same address misses.
REQ-035 With CACHE_STATS_EN: 3 hits and 2 misses -> hit_count = 3, miss_count = 2; without the macro both counters read 0.
